freq_divider_multi: RTL and testbench
=====================================

Name: freq_divider_multi

Overview:
- Parametrised successor to the single-channel fixed divider: CHANNELS independent divided clocks from one input clock.
- Each channel has a runtime-programmable divisor, a per-channel enable and a one-cycle tick strobe.
- Used as the design's central slow-clock/tick source, for example 1 Hz display, debounce and blink rates from the 50 MHz board clock.
- Divisor updates are glitch-free: they are applied only at a half-period boundary.

Parameters:
- CHANNELS, 4, number of independent divider channels (1..16).
- WIDTH, 32, divisor and counter width in bits.
- DEFAULT_DIV, 25000000, divisor loaded into every channel at reset.
- CH_W, localparam, max(1, $clog2(CHANNELS)), width of the channel select.

Ports:
- clkin  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous reset, active-low, sampled on posedge clkin.
- en  in  CHANNELS  per-channel run enable.
- cfg_we  in  1  divisor write strobe, one cycle per write.
- cfg_ch  in  CH_W  channel addressed by the write.
- cfg_div  in  WIDTH  new divisor value.
- clkout  out  CHANNELS  divided clock per channel (registered).
- tick  out  CHANNELS  one-cycle pulse coincident with each clkout rising edge (registered).
- cfg_pending  out  CHANNELS  1 = a written divisor is waiting to be applied.

Behaviour:
- Reset (rst_n=0 at a posedge): div[i]=DEFAULT_DIV, shadow[i]=0, cnt[i]=0, clkout=0, tick=0, cfg_pending=0. Reset has priority over every other input.
- Counting, en[i]=1:
  - cnt[i]==div[i] → cnt[i]<=0 and clkout[i]<=~clkout[i] ("wrap").
  - Otherwise cnt[i]<=cnt[i]+1.
  - Half-period = div+1 cycles; full period = 2*(div+1) cycles.
  - div=0 gives clkin/2.
- tick[i]<=1 only in a wrap where clkout[i] goes 0→1; 0 in every other cycle.
- Disable, en[i]=0: cnt[i]<=0, clkout[i]<=0, tick[i]<=0 on the next edge. Re-enabling restarts from phase 0, so the first rising edge comes div+1 cycles after en is sampled high.
- Writes:
  - cfg_we=1 with cfg_ch<CHANNELS → shadow[cfg_ch]<=cfg_div, cfg_pending[cfg_ch]<=1.
  - cfg_ch≥CHANNELS → write ignored, no state change.
- Apply:
  - At the next wrap of a pending channel: div<=shadow, cfg_pending<=0. The wrap itself still uses the old div.
  - If the channel is disabled: apply on the next edge.
- Write in the same cycle as a wrap (enabled channel): the value stays pending until the following wrap; the current wrap does not consume it.
- Multiple writes before apply: last write wins; cfg_pending stays 1.
- Counter arithmetic is unsigned WIDTH-bit. cnt never exceeds div, because div changes only when cnt resets to 0.
- Channels are fully independent; no cross-channel interaction apart from the shared cfg bus.
- Reset mid-period: all channels return to the reset state on that edge, and pending writes are discarded.

Optional Feature:
- Macro FREQDIV_SYNC_EN.
- Defined: adds input sync_in (1 bit).
  - When sync_in=1, on that edge every enabled channel does cnt<=0, clkout<=0, tick<=0.
  - Any pending divisor is applied on that same edge.
  - Purpose: phase-align all channels.
  - Priority: rst_n > sync_in > normal counting. Disabled channels are unaffected beyond their normal disabled behaviour.
- Undefined: no sync_in port, no sync logic. Behaviour is exactly as specified above.

Test Plan (CHANNELS=4, WIDTH=8, DEFAULT_DIV=3 unless noted):
- Reset, then en=4'b0001 → clkout[0] rises 4 cycles after en is sampled, then period 8 cycles; tick[0] high 1 cycle at each rise; channels 1–3 stay 0.
- en[1]=1, write cfg_ch=1 cfg_div=0 → cfg_pending[1]=1 until the next wrap, then clkout[1] toggles every cycle (period 2); tick[1] every 2nd cycle.
- Write cfg_ch=2 twice (5, then 9) before a wrap → after the wrap the half-period is 10 cycles; the value 5 is never used.
- Write in the exact wrap cycle of ch0 → that wrap keeps half-period 4; the next half-period uses the new divisor.
- Drop en[0] mid-period, hold 3 cycles, re-raise → clkout[0]=0 while disabled; restart at phase 0. Write with cfg_ch=3 while en[3]=0 is applied next edge, with cfg_pending[3] high for 1 cycle. Any cfg_ch out of range leaves state unchanged.
- FREQDIV_SYNC_EN, channels with divisors 3 and 5 running → pulse sync_in → both clkout=0, cnt=0 next edge; both rise together 4 and 6 cycles later. Assert rst_n=0 together with sync_in → reset state.

Source files
------------

// File: rtl/freq_divider_multi.sv
// Multi-channel programmable clock divider with per-channel enable, tick strobe
// and glitch-free divisor update. Optional phase-align input under FREQDIV_SYNC_EN.
module freq_divider_multi #(
   parameter int CHANNELS    = 4,
   parameter int WIDTH       = 32,
   parameter int DEFAULT_DIV = 25000000,
   localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clkin,
   input  logic                rst_n,
`ifdef FREQDIV_SYNC_EN
   input  logic                sync_in,
`endif
   input  logic [CHANNELS-1:0] en,
   input  logic                cfg_we,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [WIDTH-1:0]    cfg_div,
   output logic [CHANNELS-1:0] clkout,
   output logic [CHANNELS-1:0] tick,
   output logic [CHANNELS-1:0] cfg_pending
);

   localparam int                CHW1    = CH_W + 1;
   localparam logic [WIDTH-1:0]  DEF_DIV = WIDTH'(DEFAULT_DIV);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      localparam logic [CH_W:0] IDX = CHW1'(i);

      logic [WIDTH-1:0] div_q;
      logic [WIDTH-1:0] shadow_q;
      logic [WIDTH-1:0] cnt_q;
      logic             clk_q;
      logic             tick_q;
      logic             pend_q;
      logic             wr_hit;

      // Out-of-range channel numbers never match any IDX, so they are dropped here.
      assign wr_hit = cfg_we && ({1'b0, cfg_ch} == IDX);

      always_ff @(posedge clkin) begin
         if (!rst_n) begin
            div_q    <= DEF_DIV;
            shadow_q <= '0;
            cnt_q    <= '0;
            clk_q    <= 1'b0;
            tick_q   <= 1'b0;
            pend_q   <= 1'b0;
         end else begin
            tick_q <= 1'b0;
            if (!en[i]) begin
               cnt_q <= '0;
               clk_q <= 1'b0;
               if (pend_q) begin
                  div_q  <= shadow_q;
                  pend_q <= 1'b0;
               end
`ifdef FREQDIV_SYNC_EN
            end else if (sync_in) begin
               cnt_q <= '0;
               clk_q <= 1'b0;
               if (pend_q) begin
                  div_q  <= shadow_q;
                  pend_q <= 1'b0;
               end
`endif
            end else if (cnt_q == div_q) begin
               // The wrap itself runs on the old divisor; the new one governs the next half-period.
               cnt_q  <= '0;
               clk_q  <= ~clk_q;
               tick_q <= ~clk_q;
               if (pend_q) begin
                  div_q  <= shadow_q;
                  pend_q <= 1'b0;
               end
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
            // A write landing on an apply edge re-arms pending with the newer value.
            if (wr_hit) begin
               shadow_q <= cfg_div;
               pend_q   <= 1'b1;
            end
         end
      end

      assign clkout[i]      = clk_q;
      assign tick[i]        = tick_q;
      assign cfg_pending[i] = pend_q;
   end

endmodule

// File: tb/tb_freq_divider_multi.sv
// Table-driven bench for freq_divider_multi (CHANNELS=4, WIDTH=8, DEFAULT_DIV=3),
// plus hand sequences for out-of-range writes and the FREQDIV_SYNC_EN option.
module tb_freq_divider_multi;

  typedef struct {
    logic       rst_n;
    logic [3:0] en;
    logic       we;
    logic [1:0] ch;
    logic [7:0] dv;
    int         n;
    logic [3:0] c;
    logic [3:0] t;
    logic [3:0] p;
  } vec_t;

  logic       clkin;
  logic       rst_n;
  logic       sync_in;
  logic [3:0] en;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic [3:0] clkout;
  logic [3:0] tick;
  logic [3:0] cfg_pending;

  logic       rst3_n;
  logic [2:0] en3;
  logic       we3;
  logic [1:0] ch3s;
  logic [7:0] div3v;
  logic [2:0] clk3;
  logic [2:0] tick3;
  logic [2:0] pend3;

  int   total;
  int   bad;
  vec_t vecs[64];
  int   nv;

  freq_divider_multi #(.CHANNELS(4), .WIDTH(8), .DEFAULT_DIV(3)) u_dut (
    .clkin(clkin),
    .rst_n(rst_n),
`ifdef FREQDIV_SYNC_EN
    .sync_in(sync_in),
`endif
    .en(en),
    .cfg_we(cfg_we),
    .cfg_ch(cfg_ch),
    .cfg_div(cfg_div),
    .clkout(clkout),
    .tick(tick),
    .cfg_pending(cfg_pending)
  );

  freq_divider_multi #(.CHANNELS(3), .WIDTH(8), .DEFAULT_DIV(3)) u_dut3 (
    .clkin(clkin),
    .rst_n(rst3_n),
`ifdef FREQDIV_SYNC_EN
    .sync_in(1'b0),
`endif
    .en(en3),
    .cfg_we(we3),
    .cfg_ch(ch3s),
    .cfg_div(div3v),
    .clkout(clk3),
    .tick(tick3),
    .cfg_pending(pend3)
  );

  // clock / reset
  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clkin);
    #2;
  endtask

  function void add(input logic r, input logic [3:0] e, input logic w, input logic [1:0] ch,
                    input logic [7:0] dv, input int n, input logic [3:0] c, input logic [3:0] t,
                    input logic [3:0] p);
    vecs[nv].rst_n = r;
    vecs[nv].en    = e;
    vecs[nv].we    = w;
    vecs[nv].ch    = ch;
    vecs[nv].dv    = dv;
    vecs[nv].n     = n;
    vecs[nv].c     = c;
    vecs[nv].t     = t;
    vecs[nv].p     = p;
    nv++;
  endfunction

  initial begin
    int rise_at;
    total = 0; bad = 0; nv = 0;
    rst_n = 1'b0; sync_in = 1'b0; en = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
    rst3_n = 1'b0; en3 = '0; we3 = 1'b0; ch3s = '0; div3v = '0;

    // reset state
    add(0, 4'h0, 0, 0, 0, 2, 4'h0, 4'h0, 4'h0);
    // ch0 default divisor 3: rise on 4th edge, period 8
    add(1, 4'h1, 0, 0, 0, 3, 4'h0, 4'h0, 4'h0);
    add(1, 4'h1, 0, 0, 0, 1, 4'h1, 4'h1, 4'h0);
    add(1, 4'h1, 0, 0, 0, 3, 4'h1, 4'h0, 4'h0);
    add(1, 4'h1, 0, 0, 0, 4, 4'h0, 4'h0, 4'h0);
    add(1, 4'h1, 0, 0, 0, 1, 4'h1, 4'h1, 4'h0);
    // ch1 divisor 0 becomes clkin/2 after the first wrap
    add(0, 4'h0, 0, 0, 0, 1, 4'h0, 4'h0, 4'h0);
    add(1, 4'h2, 1, 1, 0, 1, 4'h0, 4'h0, 4'h2);
    add(1, 4'h2, 0, 0, 0, 2, 4'h0, 4'h0, 4'h2);
    add(1, 4'h2, 0, 0, 0, 1, 4'h2, 4'h2, 4'h0);
    add(1, 4'h2, 0, 0, 0, 1, 4'h0, 4'h0, 4'h0);
    add(1, 4'h2, 0, 0, 0, 1, 4'h2, 4'h2, 4'h0);
    add(1, 4'h2, 0, 0, 0, 1, 4'h0, 4'h0, 4'h0);
    add(1, 4'h2, 0, 0, 0, 1, 4'h2, 4'h2, 4'h0);
    // ch2 written 5 then 9: half-period 10, 5 never used
    add(0, 4'h0, 0, 0, 0, 1, 4'h0, 4'h0, 4'h0);
    add(1, 4'h4, 1, 2, 5, 1, 4'h0, 4'h0, 4'h4);
    add(1, 4'h4, 1, 2, 9, 1, 4'h0, 4'h0, 4'h4);
    add(1, 4'h4, 0, 0, 0, 1, 4'h0, 4'h0, 4'h4);
    add(1, 4'h4, 0, 0, 0, 1, 4'h4, 4'h4, 4'h0);
    add(1, 4'h4, 0, 0, 0, 9, 4'h4, 4'h0, 4'h0);
    add(1, 4'h4, 0, 0, 0, 1, 4'h0, 4'h0, 4'h0);
    add(1, 4'h4, 0, 0, 0, 9, 4'h0, 4'h0, 4'h0);
    add(1, 4'h4, 0, 0, 0, 1, 4'h4, 4'h4, 4'h0);
    // pending write discarded by reset: ch3 keeps divisor 3
    add(1, 4'h8, 1, 3, 7, 1, 4'h0, 4'h0, 4'h8);
    add(0, 4'h0, 0, 0, 0, 1, 4'h0, 4'h0, 4'h0);
    add(1, 4'h8, 0, 0, 0, 3, 4'h0, 4'h0, 4'h0);
    add(1, 4'h8, 0, 0, 0, 1, 4'h8, 4'h8, 4'h0);
    // write in ch0 wrap cycle: pending survives that wrap, applied at the next
    add(0, 4'h0, 0, 0, 0, 1, 4'h0, 4'h0, 4'h0);
    add(1, 4'h1, 0, 0, 0, 3, 4'h0, 4'h0, 4'h0);
    add(1, 4'h1, 1, 0, 1, 1, 4'h1, 4'h1, 4'h1);
    add(1, 4'h1, 0, 0, 0, 3, 4'h1, 4'h0, 4'h1);
    add(1, 4'h1, 0, 0, 0, 1, 4'h0, 4'h0, 4'h0);
    add(1, 4'h1, 0, 0, 0, 1, 4'h0, 4'h0, 4'h0);
    add(1, 4'h1, 0, 0, 0, 1, 4'h1, 4'h1, 4'h0);
    add(1, 4'h1, 0, 0, 0, 1, 4'h1, 4'h0, 4'h0);
    add(1, 4'h1, 0, 0, 0, 2, 4'h0, 4'h0, 4'h0);
    add(1, 4'h1, 0, 0, 0, 1, 4'h1, 4'h1, 4'h0);
    // disable ch0 mid-period for 3 cycles; ch3 written while disabled
    add(0, 4'h0, 0, 0, 0, 1, 4'h0, 4'h0, 4'h0);
    add(1, 4'h1, 0, 0, 0, 3, 4'h0, 4'h0, 4'h0);
    add(1, 4'h1, 0, 0, 0, 1, 4'h1, 4'h1, 4'h0);
    add(1, 4'h1, 0, 0, 0, 1, 4'h1, 4'h0, 4'h0);
    add(1, 4'h0, 1, 3, 2, 1, 4'h0, 4'h0, 4'h8);
    add(1, 4'h0, 0, 0, 0, 2, 4'h0, 4'h0, 4'h0);
    add(1, 4'h1, 0, 0, 0, 3, 4'h0, 4'h0, 4'h0);
    add(1, 4'h1, 0, 0, 0, 1, 4'h1, 4'h1, 4'h0);
    // ch3 now runs on divisor 2 alongside ch0
    add(1, 4'h9, 0, 0, 0, 2, 4'h1, 4'h0, 4'h0);
    add(1, 4'h9, 0, 0, 0, 1, 4'h9, 4'h8, 4'h0);
    add(1, 4'h9, 0, 0, 0, 1, 4'h8, 4'h0, 4'h0);
    add(1, 4'h9, 0, 0, 0, 1, 4'h8, 4'h0, 4'h0);
    add(1, 4'h9, 0, 0, 0, 1, 4'h0, 4'h0, 4'h0);

    #2;
    for (int v = 0; v < nv; v++) begin
      for (int k = 0; k < vecs[v].n; k++) begin
        rst_n   = vecs[v].rst_n;
        en      = vecs[v].en;
        cfg_we  = vecs[v].we;
        cfg_ch  = vecs[v].ch;
        cfg_div = vecs[v].dv;
        step();
        check($sformatf("v%0d.%0d clkout", v, k), 32'(clkout), 32'(vecs[v].c));
        check($sformatf("v%0d.%0d tick", v, k), 32'(tick), 32'(vecs[v].t));
        check($sformatf("v%0d.%0d pending", v, k), 32'(cfg_pending), 32'(vecs[v].p));
      end
    end
    cfg_we = 1'b0;
    en = '0;

    // out-of-range channel on a 3-channel instance
    step();
    rst3_n = 1'b1;
    we3 = 1'b1; ch3s = 2'd3; div3v = 8'd0;
    step();
    check("oor pending", 32'(pend3), 32'h0);
    we3 = 1'b0;
    en3 = 3'b111;
    rise_at = 0;
    for (int k = 1; k <= 10 && rise_at == 0; k++) begin
      step();
      if (clk3[0]) rise_at = k;
    end
    check("oor ch0 first rise edge", 32'(rise_at), 32'd4);
    check("oor all channels", 32'(clk3), 32'h7);

`ifdef FREQDIV_SYNC_EN
    // phase alignment: ch0 div 3, ch1 div 5
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd5;
    step();
    cfg_we = 1'b0;
    step();
    check("sync ch1 applied", 32'(cfg_pending), 32'h0);
    en = 4'h3;
    for (int k = 0; k < 7; k++) step();
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    check("sync clkout", 32'(clkout), 32'h0);
    check("sync tick", 32'(tick), 32'h0);
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k < 4) check($sformatf("sync +%0d", k), 32'(clkout), 32'h0);
      if (k == 4) check("sync +4 ch0 rise", 32'(tick), 32'h1);
      if (k == 6) check("sync +6 ch1 rise", 32'(tick), 32'h2);
    end
    sync_in = 1'b1;
    rst_n = 1'b0;
    step();
    check("sync+reset clkout", 32'(clkout), 32'h0);
    check("sync+reset pending", 32'(cfg_pending), 32'h0);
    sync_in = 1'b0;
    rst_n = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
